ex_operand_stage: RTL and testbench

// ID/EX pipeline register sitting directly upstream of the ALU. Captures one decoded instruction
// (register values, immediate, PC, alu_control), resolves operand forwarding from the MEM and WB

---
 rtl/ex_operand_stage_pkg.sv | 32 +++
 rtl/ex_operand_stage_fwd_resolve.sv | 38 +++
 rtl/ex_operand_stage.sv | 156 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: operand-select codes beside the ALU opcodes,
// plus the register-match helper used by forwarding.
package ex_operand_stage_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'd0,
      OPA_PC   = 2'd1,
      OPA_ZERO = 2'd2
   } opa_sel_e;

   typedef enum logic [1:0] {
      OPB_RS2  = 2'd0,
      OPB_IMM  = 2'd1,
      OPB_FOUR = 2'd2
   } opb_sel_e;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_XOR = 5'd4;

   // x0 is hard-wired, so a producer targeting it never forwards.
   function automatic logic reg_match(input logic wen,
                                      input logic [REG_IDX_W-1:0] rd,
                                      input logic [REG_IDX_W-1:0] rs);
      return wen && (rd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_resolve.sv
// Forwarding resolver for one source register: MEM beats WB beats the stored value,
// and reports when the MEM producer is a load whose data is not yet available.
module ex_operand_stage_fwd_resolve
   import ex_operand_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [REG_IDX_W-1:0] rs,
   input  logic [XLEN-1:0]      stored_val,
   input  logic                 mem_wen,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [XLEN-1:0]      mem_val,
   input  logic                 mem_is_load,
   input  logic                 wb_wen,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_val,
   output logic [XLEN-1:0]      fwd_val,
   output logic                 load_hazard
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit     = reg_match(mem_wen, mem_rd, rs);
      wb_hit      = reg_match(wb_wen, wb_rd, rs);
      load_hazard = mem_hit && mem_is_load;
      fwd_val     = stored_val;
      if (rs == '0) begin
         fwd_val = '0;
      end else if (mem_hit) begin
         fwd_val = mem_val;
      end else if (wb_hit) begin
         fwd_val = wb_val;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: one held instruction, live operand forwarding,
// valid/ready handshake with flush and load-use interlock.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic [XLEN-1:0]      in_rs1_val,
   input  logic [XLEN-1:0]      in_rs2_val,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic [1:0]           in_opa_sel,
   input  logic [1:0]           in_opb_sel,
   input  logic [CTRL_W-1:0]    in_alu_control,
   input  logic                 flush,
   input  logic                 mem_wen,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [XLEN-1:0]      mem_val,
   input  logic                 mem_is_load,
   input  logic                 wb_wen,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_val,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      a,
   output logic [XLEN-1:0]      b,
   output logic [CTRL_W-1:0]    alu_control,
   output logic [XLEN-1:0]      store_data,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic [XLEN-1:0]      out_pc,
   output logic                 load_use_stall
);

   logic                 held_valid_reg;
   logic [XLEN-1:0]      pc_reg;
   logic [XLEN-1:0]      imm_reg;
   logic [REG_IDX_W-1:0] rs1_reg;
   logic [REG_IDX_W-1:0] rs2_reg;
   logic [XLEN-1:0]      rs1_val_reg;
   logic [XLEN-1:0]      rs2_val_reg;
   logic [REG_IDX_W-1:0] rd_reg;
   logic [1:0]           opa_sel_reg;
   logic [1:0]           opb_sel_reg;
   logic [CTRL_W-1:0]    alu_control_reg;

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            rs1_hazard;
   logic            rs2_hazard;
   logic            retire;
   logic            capture;

   ex_operand_stage_fwd_resolve #(.XLEN(XLEN)) fwd_rs1 (
      .rs          (rs1_reg),
      .stored_val  (rs1_val_reg),
      .mem_wen     (mem_wen),
      .mem_rd      (mem_rd),
      .mem_val     (mem_val),
      .mem_is_load (mem_is_load),
      .wb_wen      (wb_wen),
      .wb_rd       (wb_rd),
      .wb_val      (wb_val),
      .fwd_val     (rs1_fwd),
      .load_hazard (rs1_hazard)
   );

   ex_operand_stage_fwd_resolve #(.XLEN(XLEN)) fwd_rs2 (
      .rs          (rs2_reg),
      .stored_val  (rs2_val_reg),
      .mem_wen     (mem_wen),
      .mem_rd      (mem_rd),
      .mem_val     (mem_val),
      .mem_is_load (mem_is_load),
      .wb_wen      (wb_wen),
      .wb_rd       (wb_rd),
      .wb_val      (wb_val),
      .fwd_val     (rs2_fwd),
      .load_hazard (rs2_hazard)
   );

   // rs2 always feeds store_data, so its hazard stalls regardless of the B select.
   always_comb begin
      load_use_stall = held_valid_reg &&
                       ((rs1_hazard && (opa_sel_reg == OPA_RS1)) || rs2_hazard);
      out_valid      = held_valid_reg && !load_use_stall;
      retire         = out_valid && out_ready;
      in_ready       = !flush && (!held_valid_reg || retire);
      capture        = in_valid && in_ready;
   end

   always_comb begin
      a = '0;
      case (opa_sel_reg)
         OPA_RS1: a = rs1_fwd;
         OPA_PC:  a = pc_reg;
         default: a = '0;
      endcase
      b = '0;
      case (opb_sel_reg)
         OPB_RS2:  b = rs2_fwd;
         OPB_IMM:  b = imm_reg;
         OPB_FOUR: b = XLEN'(4);
         default:  b = '0;
      endcase
   end

   assign store_data  = rs2_fwd;
   assign out_rd      = rd_reg;
   assign out_pc      = pc_reg;
   assign alu_control = alu_control_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         held_valid_reg  <= 1'b0;
         pc_reg          <= '0;
         imm_reg         <= '0;
         rs1_reg         <= '0;
         rs2_reg         <= '0;
         rs1_val_reg     <= '0;
         rs2_val_reg     <= '0;
         rd_reg          <= '0;
         opa_sel_reg     <= '0;
         opb_sel_reg     <= '0;
         alu_control_reg <= '0;
      end else if (flush) begin
         held_valid_reg <= 1'b0;
      end else if (capture) begin
         held_valid_reg  <= 1'b1;
         pc_reg          <= in_pc;
         imm_reg         <= in_imm;
         rs1_reg         <= in_rs1;
         rs2_reg         <= in_rs2;
         rs1_val_reg     <= in_rs1_val;
         rs2_val_reg     <= in_rs2_val;
         rd_reg          <= in_rd;
         opa_sel_reg     <= in_opa_sel;
         opb_sel_reg     <= in_opb_sel;
         alu_control_reg <= in_alu_control;
      end else if (retire) begin
         held_valid_reg <= 1'b0;
      end else if (held_valid_reg) begin
         // Absorb producers while waiting; a pending load's MEM value is an address, not data.
         rs1_val_reg <= rs1_hazard ? rs1_val_reg : rs1_fwd;
         rs2_val_reg <= rs2_hazard ? rs2_val_reg : rs2_fwd;
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected ALU beats are queued at issue and
// popped when the stage presents them.
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_imm, in_rs1_val, in_rs2_val;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [1:0]  in_opa_sel, in_opb_sel;
   logic [4:0]  in_alu_control;
   logic        flush;
   logic        mem_wen, mem_is_load;
   logic [4:0]  mem_rd;
   logic [31:0] mem_val;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_val;
   logic        out_valid, out_ready;
   logic [31:0] a, b, store_data, out_pc;
   logic [4:0]  alu_control, out_rd;
   logic        load_use_stall;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [4:0]  ctrl;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_imm         (in_imm),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_rs1_val     (in_rs1_val),
      .in_rs2_val     (in_rs2_val),
      .in_rd          (in_rd),
      .in_opa_sel     (in_opa_sel),
      .in_opb_sel     (in_opb_sel),
      .in_alu_control (in_alu_control),
      .flush          (flush),
      .mem_wen        (mem_wen),
      .mem_rd         (mem_rd),
      .mem_val        (mem_val),
      .mem_is_load    (mem_is_load),
      .wb_wen         (wb_wen),
      .wb_rd          (wb_rd),
      .wb_val         (wb_val),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .a              (a),
      .b              (b),
      .alu_control    (alu_control),
      .store_data     (store_data),
      .out_rd         (out_rd),
      .out_pc         (out_pc),
      .load_use_stall (load_use_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] esd,
                           input logic [4:0] erd, input logic [31:0] epc, input logic [4:0] ectrl);
      exp_t e;
      e.a = ea; e.b = eb; e.sd = esd; e.rd = erd; e.pc = epc; e.ctrl = ectrl;
      sb.push_back(e);
   endtask

   task automatic check_beat(input string tag);
      exp_t e;
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      tests++;
      assert (sb.size() > 0) else begin
         failed++;
         $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_a"}, a, e.a);
         chk({tag, "_b"}, b, e.b);
         chk({tag, "_store_data"}, store_data, e.sd);
         chk({tag, "_out_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
         chk({tag, "_out_pc"}, out_pc, e.pc);
         chk({tag, "_alu_control"}, {27'd0, alu_control}, {27'd0, e.ctrl});
         $display("[TB] beat %s a=0x%0h b=0x%0h pc=0x%0h", tag, a, b, out_pc);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [31:0] rs1v,
                        input logic [4:0] rs2, input logic [31:0] rs2v,
                        input logic [4:0] rd, input logic [1:0] opa, input logic [1:0] opb,
                        input logic [4:0] ctrl);
      in_valid = 1'b1; in_pc = pc; in_imm = imm;
      in_rs1 = rs1; in_rs1_val = rs1v; in_rs2 = rs2; in_rs2_val = rs2v;
      in_rd = rd; in_opa_sel = opa; in_opb_sel = opb; in_alu_control = ctrl;
   endtask

   task automatic clear_producers();
      mem_wen = 1'b0; mem_rd = '0; mem_val = '0; mem_is_load = 1'b0;
      wb_wen = 1'b0; wb_rd = '0; wb_val = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
      in_rs1_val = '0; in_rs2_val = '0; in_rd = '0; in_opa_sel = '0; in_opb_sel = '0;
      in_alu_control = '0;
      clear_producers();
      step(); step();
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_a", a, 32'd0);
      chk("rst_b", b, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_alu_control", {27'd0, alu_control}, 32'd0);

      // Plain capture, one-cycle latency
      step();
      drive(32'h100, 32'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, OPA_RS1, OPB_RS2, ALU_ADD);
      push_exp(32'd5, 32'd7, 32'd7, 5'd3, 32'h100, ALU_ADD);
      @(negedge clk);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check_beat("t1");

      // MEM forward has priority over WB
      step();
      drive(32'h104, 32'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd4, OPA_RS1, OPB_RS2, ALU_ADD);
      push_exp(32'd9, 32'd7, 32'd7, 5'd4, 32'h104, ALU_ADD);
      step();
      in_valid = 1'b0;
      mem_wen = 1'b1; mem_rd = 5'd1; mem_val = 32'd9;
      wb_wen = 1'b1; wb_rd = 5'd1; wb_val = 32'd3;
      @(negedge clk);
      check_beat("t2_mem_prio");

      // x0 never forwards
      step();
      clear_producers();
      drive(32'h108, 32'h30, 5'd0, 32'h55, 5'd2, 32'd7, 5'd5, OPA_RS1, OPB_IMM, ALU_OR);
      push_exp(32'd0, 32'h30, 32'd7, 5'd5, 32'h108, ALU_OR);
      step();
      in_valid = 1'b0;
      mem_wen = 1'b1; mem_rd = 5'd0; mem_val = 32'hFFFF;
      @(negedge clk);
      check_beat("t3_x0");

      // Load-use interlock, resolved from WB next cycle
      step();
      clear_producers();
      drive(32'h10C, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd6, OPA_RS1, OPB_RS2, ALU_SUB);
      push_exp(32'd5, 32'h40, 32'h40, 5'd6, 32'h10C, ALU_SUB);
      step();
      in_valid = 1'b0;
      mem_wen = 1'b1; mem_rd = 5'd2; mem_val = 32'h999; mem_is_load = 1'b1;
      @(negedge clk);
      chk("t4_stall", {31'd0, load_use_stall}, 32'd1);
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      clear_producers();
      wb_wen = 1'b1; wb_rd = 5'd2; wb_val = 32'h40;
      @(negedge clk);
      chk("t4_stall_clear", {31'd0, load_use_stall}, 32'd0);
      check_beat("t4_load_use");

      // Refresh keeps a WB value that leaves mid-stall
      step();
      clear_producers();
      out_ready = 1'b0;
      drive(32'h110, 32'h0, 5'd1, 32'd1, 5'd2, 32'd7, 5'd7, OPA_RS1, OPB_RS2, ALU_ADD);
      push_exp(32'h11, 32'd7, 32'd7, 5'd7, 32'h110, ALU_ADD);
      step();
      in_valid = 1'b0;
      wb_wen = 1'b1; wb_rd = 5'd1; wb_val = 32'h11;
      @(negedge clk);
      chk("t5_c1_a", a, 32'h11);
      step();
      clear_producers();
      @(negedge clk);
      chk("t5_c2_a", a, 32'h11);
      step();
      @(negedge clk);
      chk("t5_c3_a", a, 32'h11);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      check_beat("t5_refresh");

      // Retire and capture in the same cycle: no bubble
      step();
      drive(32'h200, 32'h8, 5'd3, 32'h30, 5'd4, 32'h40, 5'd8, OPA_RS1, OPB_IMM, ALU_ADD);
      push_exp(32'h30, 32'h8, 32'h40, 5'd8, 32'h200, ALU_ADD);
      step();
      drive(32'h204, 32'h0, 5'd3, 32'h31, 5'd4, 32'h41, 5'd9, OPA_PC, OPB_FOUR, ALU_ADD);
      push_exp(32'h204, 32'd4, 32'h41, 5'd9, 32'h204, ALU_ADD);
      @(negedge clk);
      chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
      check_beat("t6_a");
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check_beat("t6_b");

      // Flush beats capture and retire
      step();
      out_ready = 1'b0;
      drive(32'h300, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd10, OPA_RS1, OPB_RS2, ALU_AND);
      step();
      flush = 1'b1;
      drive(32'h304, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd11, OPA_RS1, OPB_RS2, ALU_AND);
      @(negedge clk);
      chk("t7_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t7_flushed", {31'd0, out_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("t7_dropped", {31'd0, out_valid}, 32'd0);

      // Select encoding 3 drives zero on both operands
      step();
      drive(32'h400, 32'h5, 5'd1, 32'h77, 5'd2, 32'h88, 5'd12, 2'd3, 2'd3, ALU_XOR);
      push_exp(32'd0, 32'd0, 32'h88, 5'd12, 32'h400, ALU_XOR);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check_beat("t8_sel3");

      // Reset while holding discards the entry
      step();
      out_ready = 1'b0;
      drive(32'h500, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd13, OPA_RS1, OPB_RS2, ALU_ADD);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t9_held", {31'd0, out_valid}, 32'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t9_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t9_out_pc", out_pc, 32'd0);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
